flag_frame_ctrl: RTL and testbench

Parametrised successor of the overload-frame checker, with the same sample-point driven bit handling. It generates and supervises the CAN overload frame, the error-active frame and the error-passive frame. Per frame it drives the flag on canTX, tolerates superposed flags from other nodes and counts the delimiter. It reports end of frame, invalid bits, bit errors and a chained overload request to the frame-maker FSM. It sits between the bit-timing unit (which supplies samplePoint) and the frame-maker top level.

---
 rtl/flag_frame_ctrl.sv | 111 +++++++++++
 tb/tb_flag_frame_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/flag_frame_ctrl.sv
// flag_frame_ctrl: drives and supervises CAN overload, error-active and error-passive flags plus delimiter.
// One shared counter serves flag, equal-bit, dominant-extension and delimiter counting.
module flag_frame_ctrl #(
    parameter int FLAG_LEN  = 6,
    parameter int DELIM_LEN = 8,
    parameter int MAX_EXT   = 8,
    parameter int AUTO_OVL  = 1,
    parameter int CW        = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       samplePoint,
    input  logic       canRX,
    input  logic       startFrame,
    input  logic [1:0] frameType,
    output logic       canTX,
    output logic       busy,
    output logic       endFrame,
    output logic       invalidBit,
    output logic       bitError,
    output logic       overloadReq
);
    typedef enum logic [1:0] {IDLE, FLAG, SUPERPOS, DELIM} state_t;
    state_t state, state_n;
    logic passive, passive_n, prev, prev_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic end_n, inv_n, berr_n, ovl_n;

    if ((2**CW) <= FLAG_LEN || (2**CW) <= DELIM_LEN || (2**CW) <= MAX_EXT) begin : g_cw_check
        $error("flag_frame_ctrl: CW too small for FLAG_LEN/DELIM_LEN/MAX_EXT");
    end

    always_comb begin
        state_n   = state;
        passive_n = passive;
        prev_n    = prev;
        cnt_n     = cnt;
        end_n     = 1'b0;
        inv_n     = 1'b0;
        berr_n    = 1'b0;
        ovl_n     = 1'b0;
        cnt_inc   = cnt + 1'b1;
        case (state)
            IDLE: if (startFrame) begin
                state_n   = FLAG;
                passive_n = frameType == 2'd2;
                cnt_n     = '0;
                prev_n    = 1'b1;
            end
            FLAG: if (samplePoint) begin
                // cnt==0 in passive mode means no previous sample yet
                cnt_n  = (!passive || (cnt != '0 && canRX == prev)) ? cnt_inc : CW'(1);
                prev_n = canRX;
                berr_n = !passive && canRX;
                if (cnt_n == CW'(FLAG_LEN)) begin
                    state_n = SUPERPOS;
                    cnt_n   = '0;
                end
            end
            SUPERPOS: if (samplePoint) begin
                if (canRX) begin
                    state_n = DELIM;
                    cnt_n   = CW'(1);
                end else begin
                    inv_n = cnt_inc == CW'(MAX_EXT);
                    cnt_n = inv_n ? '0 : cnt_inc;
                end
            end
            DELIM: if (samplePoint) begin
                if (canRX) begin
                    end_n   = cnt_inc == CW'(DELIM_LEN);
                    cnt_n   = end_n ? '0 : cnt_inc;
                    state_n = end_n ? IDLE : DELIM;
                end else begin
                    ovl_n     = cnt == CW'(DELIM_LEN - 1);
                    inv_n     = !(ovl_n && AUTO_OVL != 0);
                    state_n   = inv_n ? IDLE : FLAG;
                    passive_n = inv_n ? passive : 1'b0;
                    cnt_n     = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            passive     <= 1'b0;
            prev        <= 1'b1;
            cnt         <= '0;
            canTX       <= 1'b1;
            busy        <= 1'b0;
            endFrame    <= 1'b0;
            invalidBit  <= 1'b0;
            bitError    <= 1'b0;
            overloadReq <= 1'b0;
        end else begin
            state       <= state_n;
            passive     <= passive_n;
            prev        <= prev_n;
            cnt         <= cnt_n;
            canTX       <= !(state_n == FLAG && !passive_n);
            busy        <= state_n != IDLE;
            endFrame    <= end_n;
            invalidBit  <= inv_n;
            bitError    <= berr_n;
            overloadReq <= ovl_n;
        end
    end
endmodule

// File: tb/tb_flag_frame_ctrl.sv
// tb_flag_frame_ctrl: vector table, directed corner sequences and random traffic against a frame-level model.
module tb_flag_frame_ctrl;
    localparam int FLAG_LEN = 6, DELIM_LEN = 8, MAX_EXT = 8;
    logic clock = 1'b0, reset = 1'b1, samplePoint = 1'b0, canRX = 1'b1, startFrame = 1'b0;
    logic [1:0] frameType = 2'd0;
    logic tx0, busy0, end0, inv0, berr0, ovl0;
    logic tx1, busy1, end1, inv1, berr1, ovl1;
    logic [5:0] o[2];
    int checks = 0, errors = 0;

    flag_frame_ctrl #(.AUTO_OVL(1)) u0 (.clock(clock), .reset(reset), .samplePoint(samplePoint), .canRX(canRX),
        .startFrame(startFrame), .frameType(frameType), .canTX(tx0), .busy(busy0), .endFrame(end0),
        .invalidBit(inv0), .bitError(berr0), .overloadReq(ovl0));
    flag_frame_ctrl #(.AUTO_OVL(0)) u1 (.clock(clock), .reset(reset), .samplePoint(samplePoint), .canRX(canRX),
        .startFrame(startFrame), .frameType(frameType), .canTX(tx1), .busy(busy1), .endFrame(end1),
        .invalidBit(inv1), .bitError(berr1), .overloadReq(ovl1));

    assign o[0] = {tx0, busy0, end0, inv0, berr0, ovl0};
    assign o[1] = {tx1, busy1, end1, inv1, berr1, ovl1};

    always #5 clock = ~clock;

    // Frame-level model: phase 0 idle, 1 flag, 2 superposition, 3 delimiter; outputs {tx,busy,end,inv,berr,ovl}
    int ph[2], n[2], hn[2];
    bit pas[2];
    bit hist[2][256];
    logic [5:0] em[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            ph[i] = 0; n[i] = 0; hn[i] = 0; pas[i] = 0; em[i] = 6'b100000;
        end
    endtask

    task automatic model_step(input bit sp, input bit rx, input bit sf, input bit [1:0] ft);
        for (int i = 0; i < 2; i++) begin
            bit e = 0, inv = 0, be = 0, ov = 0, same;
            case (ph[i])
                0: if (sf) begin ph[i] = 1; pas[i] = ft == 2; n[i] = 0; hn[i] = 0; end
                1: if (sp) begin
                    if (pas[i]) begin
                        hist[i][hn[i] % 256] = rx;
                        hn[i]++;
                        same = hn[i] >= FLAG_LEN;
                        for (int k = 1; k < FLAG_LEN; k++)
                            if (same && hist[i][(hn[i] - 1 - k) % 256] != rx) same = 0;
                        if (same) begin ph[i] = 2; n[i] = 0; end
                    end else begin
                        be = rx;
                        n[i]++;
                        if (n[i] == FLAG_LEN) begin ph[i] = 2; n[i] = 0; end
                    end
                end
                2: if (sp) begin
                    if (rx) begin ph[i] = 3; n[i] = 1; end
                    else begin n[i]++; inv = n[i] % MAX_EXT == 0; end
                end
                default: if (sp) begin
                    if (rx) begin n[i]++; if (n[i] == DELIM_LEN) begin e = 1; ph[i] = 0; end end
                    else if (n[i] == DELIM_LEN - 1) begin
                        ov = 1;
                        if (i == 0) begin ph[i] = 1; pas[i] = 0; n[i] = 0; hn[i] = 0; end
                        else begin inv = 1; ph[i] = 0; end
                    end else begin inv = 1; ph[i] = 0; end
                end
            endcase
            em[i] = {!(ph[i] == 1 && !pas[i]), ph[i] != 0, e, inv, be, ov};
        end
    endtask

    task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (tx,busy,end,inv,berr,ovl) at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit sp, input bit rx, input bit sf, input bit [1:0] ft);
        @(negedge clock);
        samplePoint = sp; canRX = rx; startFrame = sf; frameType = ft;
        @(posedge clock);
        model_step(sp, rx, sf, ft);
        #1;
        chk("model_u0", o[0], em[0]);
        chk("model_u1", o[1], em[1]);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2 reset = 1'b1;
        samplePoint = 0; startFrame = 0; canRX = 1;
        #1;
        model_reset();
        chk("async_reset_u0", o[0], 6'b100000);
        chk("async_reset_u1", o[1], 6'b100000);
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    typedef struct {bit sp; bit rx; bit sf; bit [1:0] ft; logic [5:0] exp;} vec_t;
    vec_t tab[15];

    initial begin
        int cnt;
        bit bias;
        for (int j = 0; j < 15; j++) begin
            tab[j].sp = j != 0; tab[j].sf = j == 0; tab[j].ft = 2'd0; tab[j].rx = j >= 7;
            tab[j].exp = j == 14 ? 6'b101000 : (j >= 6 ? 6'b110000 : 6'b010000);
        end
        model_reset();
        do_reset();
        cyc(0, 1, 0, 0);

        // mode 0 nominal frame from the vector table
        for (int j = 0; j < 15; j++) begin
            cyc(tab[j].sp, tab[j].rx, tab[j].sf, tab[j].ft);
            chk($sformatf("tab%0d_u0", j), o[0], tab[j].exp);
            chk($sformatf("tab%0d_u1", j), o[1], tab[j].exp);
        end

        // reset in the middle of an active flag
        cyc(0, 1, 1, 1);
        for (int j = 0; j < 3; j++) cyc(1, 0, 0, 0);
        chk("midflag_tx", o[0], 6'b010000);
        do_reset();
        cyc(0, 1, 0, 0);
        chk("after_reset", o[0], 6'b100000);

        // bitError on flag bit 3, ignored start while busy, frame still completes
        cyc(0, 1, 1, 3);
        cnt = 0;
        for (int j = 1; j <= 6; j++) begin
            cyc(1, j == 3, j == 2, 2'd2);
            cnt += int'(berr0);
        end
        for (int j = 1; j <= 8; j++) begin
            cyc(1, 1, 0, 0);
            cnt += int'(berr0);
            if (j == 8) chk("berr_frame_end", o[0], 6'b101000);
        end
        chk("berr_count", 6'(cnt), 6'd1);

        // sixteen dominant bits after the flag
        cyc(0, 1, 1, 1);
        for (int j = 0; j < 6; j++) cyc(1, 0, 0, 0);
        for (int j = 1; j <= 16; j++) begin
            cyc(1, 0, 0, 0);
            chk($sformatf("ext_inv%0d", j), {5'd0, inv0}, {5'd0, j % 8 == 0});
        end
        for (int j = 0; j < 8; j++) cyc(1, 1, 0, 0);
        chk("ext_end", o[0], 6'b101000);

        // dominant at last delimiter bit: auto restart vs idle
        cyc(0, 1, 1, 0);
        for (int j = 0; j < 6; j++) cyc(1, 0, 0, 0);
        for (int j = 0; j < 7; j++) cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        chk("ovl_auto", o[0], 6'b010001);
        chk("ovl_noauto", o[1], 6'b100101);
        do_reset();

        // passive flag with bus pattern 1,1,0,0,0,0,0,0 then dominant at delimiter bit 3
        cyc(0, 1, 1, 2);
        for (int j = 0; j < 8; j++) begin
            cyc(1, j < 2, 0, 0);
            chk($sformatf("pas_tx%0d", j), {5'd0, tx0}, 6'd1);
        end
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        chk("pas_delim3", o[0], 6'b100100);

        // random traffic against the model
        bias = 0;
        for (int j = 0; j < 4000; j++) begin
            if (j % 40 == 0) bias = 1'($urandom);
            cyc($urandom % 3 == 0, bias ? ($urandom % 5 != 0) : ($urandom % 5 == 0),
                $urandom % 15 == 0, 2'($urandom));
            if (j % 1000 == 999) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
